// File: rtl/ctrl_pkg.sv
// Shared opcode, state and ALU-select encodings for the parameterised control unit.
package ctrl_pkg;

    localparam logic [3:0] OP_NOOP  = 4'd0;
    localparam logic [3:0] OP_STORE = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_HALT  = 4'd5;
    localparam logic [3:0] OP_JUMP  = 4'd6;
    localparam logic [3:0] OP_JZ    = 4'd7;

    localparam logic [2:0] ALU_NONE = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;

    typedef enum logic [4:0] {
        S_INIT    = 5'd0,
        S_FETCH   = 5'd1,
        S_DECODE  = 5'd2,
        S_NOOP    = 5'd3,
        S_LOAD_A  = 5'd4,
        S_LOAD_B  = 5'd5,
        S_STORE_A = 5'd6,
        S_STORE_B = 5'd7,
        S_ARITH_A = 5'd8,
        S_ARITH_B = 5'd9,
        S_JUMP    = 5'd10,
        S_JZ      = 5'd11,
        S_HALT    = 5'd12,
        S_ERROR   = 5'd13
    } state_t;

    function automatic logic [2:0] alu_sel(input logic [3:0] op);
        return (op == OP_SUB) ? ALU_SUB : ALU_ADD;
    endfunction

endpackage

// File: rtl/ctrl_unit_param_if.sv
// Bus between the control unit (master) and the datapath/memory it steers (slave).
interface ctrl_unit_param_if #(
    parameter int AW = 8,
    parameter int RW = 4,
    parameter int PW = 8
);
    localparam int IW = 4 + AW + RW;

    logic [IW-1:0] IR;
    logic          D_rdy;
    logic          RF_A_zero;
    logic          Resume;

    logic [AW-1:0] D_addr;
    logic          D_wr;
    logic          IR_ld;
    logic          PC_clr;
    logic          PC_inc;
    logic          PC_ld;
    logic [PW-1:0] PC_target;
    logic [RW-1:0] RF_A_addr;
    logic [RW-1:0] RF_B_addr;
    logic          RF_WenA;
    logic          RF_WenB;
    logic [2:0]    ALU_S;
    logic          Halted;
    logic          Err;
    logic [4:0]    State;

    modport master (
        input  IR, D_rdy, RF_A_zero, Resume,
        output D_addr, D_wr, IR_ld, PC_clr, PC_inc, PC_ld, PC_target,
               RF_A_addr, RF_B_addr, RF_WenA, RF_WenB, ALU_S, Halted, Err, State
    );

    modport slave (
        output IR, D_rdy, RF_A_zero, Resume,
        input  D_addr, D_wr, IR_ld, PC_clr, PC_inc, PC_ld, PC_target,
               RF_A_addr, RF_B_addr, RF_WenA, RF_WenB, ALU_S, Halted, Err, State
    );
endinterface

// File: rtl/ctrl_wait_timer.sv
// Counts memory wait cycles; expired fires on the wait cycle that would bring the count to TMO.
module ctrl_wait_timer #(
    parameter int TMO = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic expired
);
    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (tick) begin
            r_count <= r_count + 8'd1;
        end
    end

    // A ready in the final cycle suppresses tick, so completion wins over timeout.
    assign expired = tick && (r_count == 8'(TMO - 1));
endmodule

// File: rtl/ctrl_unit_param.sv
// Multi-cycle instruction sequencer: decodes IR and drives PC, register-file, ALU and data-memory controls.
module ctrl_unit_param
    import ctrl_pkg::*;
#(
    parameter int AW  = 8,
    parameter int RW  = 4,
    parameter int PW  = 8,
    parameter int TMO = 15
) (
    input  logic Clk,
    input  logic Reset_n,
    ctrl_unit_param_if.master bus
);
    localparam int IW = 4 + AW + RW;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    w_op;
    logic          w_waiting;
    logic          w_expired;

    logic [AW-1:0] w_d_addr;
    logic          w_d_wr, w_ir_ld, w_pc_clr, w_pc_inc, w_pc_ld;
    logic [PW-1:0] w_pc_target;
    logic [RW-1:0] w_rf_a_addr, w_rf_b_addr;
    logic          w_rf_wena, w_rf_wenb, w_halted, w_err;
    logic [2:0]    w_alu_s;

    assign w_op      = bus.IR[IW-1:IW-4];
    assign w_waiting = (r_state == S_LOAD_A) || (r_state == S_STORE_B);

    // Held clear outside the two wait states, so every entry starts from zero.
    ctrl_wait_timer #(.TMO(TMO)) u_timer (
        .clk     (Clk),
        .rst_n   (Reset_n),
        .clr     (!w_waiting),
        .tick    (w_waiting && !bus.D_rdy),
        .expired (w_expired)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= S_INIT;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:    w_next = S_FETCH;
            S_FETCH:   w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_NOOP:         w_next = S_NOOP;
                    OP_STORE:        w_next = S_STORE_A;
                    OP_LOAD:         w_next = S_LOAD_A;
                    OP_ADD, OP_SUB:  w_next = S_ARITH_A;
                    OP_HALT:         w_next = S_HALT;
                    OP_JUMP:         w_next = S_JUMP;
                    OP_JZ:           w_next = S_JZ;
                    default:         w_next = S_ERROR;
                endcase
            end
            S_NOOP:    w_next = S_FETCH;
            S_LOAD_A:  w_next = bus.D_rdy ? S_LOAD_B : (w_expired ? S_ERROR : S_LOAD_A);
            S_LOAD_B:  w_next = S_FETCH;
            S_STORE_A: w_next = S_STORE_B;
            S_STORE_B: w_next = bus.D_rdy ? S_FETCH : (w_expired ? S_ERROR : S_STORE_B);
            S_ARITH_A: w_next = S_ARITH_B;
            S_ARITH_B: w_next = S_FETCH;
            S_JUMP:    w_next = S_FETCH;
            S_JZ:      w_next = S_FETCH;
            S_HALT:    w_next = bus.Resume ? S_FETCH : S_HALT;
            S_ERROR:   w_next = S_ERROR;
            default:   w_next = S_ERROR;
        endcase
    end

    always_comb begin
        w_d_addr    = '0;
        w_d_wr      = 1'b0;
        w_ir_ld     = 1'b0;
        w_pc_clr    = 1'b0;
        w_pc_inc    = 1'b0;
        w_pc_ld     = 1'b0;
        w_pc_target = '0;
        w_rf_a_addr = '0;
        w_rf_b_addr = '0;
        w_rf_wena   = 1'b0;
        w_rf_wenb   = 1'b0;
        w_alu_s     = ALU_NONE;
        w_halted    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_INIT:    w_pc_clr = 1'b1;
            S_FETCH:   w_ir_ld  = 1'b1;
            S_DECODE:  w_pc_inc = 1'b1;
            S_LOAD_A:  w_d_addr = bus.IR[AW+RW-1:RW];
            S_LOAD_B: begin
                w_d_addr    = bus.IR[AW+RW-1:RW];
                w_rf_a_addr = bus.IR[RW-1:0];
                w_rf_wena   = 1'b1;
            end
            S_STORE_A: w_rf_a_addr = bus.IR[AW+RW-1:AW];
            S_STORE_B: begin
                w_d_addr = bus.IR[AW-1:0];
                w_d_wr   = 1'b1;
            end
            S_ARITH_A: begin
                w_rf_a_addr = bus.IR[AW+RW-1:AW];
                w_rf_b_addr = bus.IR[AW-1:AW-RW];
                w_alu_s     = alu_sel(w_op);
            end
            S_ARITH_B: begin
                w_rf_b_addr = bus.IR[RW-1:0];
                w_rf_wenb   = 1'b1;
                w_alu_s     = alu_sel(w_op);
            end
            S_JUMP: begin
                w_pc_ld     = 1'b1;
                w_pc_target = bus.IR[PW-1:0];
            end
            S_JZ: begin
                w_rf_a_addr = bus.IR[AW+RW-1:AW];
                w_pc_target = bus.IR[PW-1:0];
                w_pc_ld     = bus.RF_A_zero;
            end
            S_HALT:    w_halted = 1'b1;
            S_ERROR:   w_err    = 1'b1;
            default: ;
        endcase
    end

    assign bus.D_addr    = w_d_addr;
    assign bus.D_wr      = w_d_wr;
    assign bus.IR_ld     = w_ir_ld;
    assign bus.PC_clr    = w_pc_clr;
    assign bus.PC_inc    = w_pc_inc;
    assign bus.PC_ld     = w_pc_ld;
    assign bus.PC_target = w_pc_target;
    assign bus.RF_A_addr = w_rf_a_addr;
    assign bus.RF_B_addr = w_rf_b_addr;
    assign bus.RF_WenA   = w_rf_wena;
    assign bus.RF_WenB   = w_rf_wenb;
    assign bus.ALU_S     = w_alu_s;
    assign bus.Halted    = w_halted;
    assign bus.Err       = w_err;
    assign bus.State     = r_state;
endmodule
